// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps PC, issues LUT index on taken bnzl, applies signed offset.
// Optional BranchCount output is enabled by defining BRANCH_COUNT_EN.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic              Halt,
  input  logic              BranchEn,
  input  logic [3:0]        BranchSel,
  input  logic [10:0]       LutOut,
  output logic [3:0]        LutIndex,
  output logic [ADDR_W-1:0] PC,
  output logic              Stall,
  output logic              Busy,
  output logic              Done,
  output logic [CNT_W-1:0]  Cycles
`ifdef BRANCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]  BranchCount
`endif
);

  // state    | meaning
  // S_IDLE   | waiting for first Start after reset
  // S_RUN    | stepping PC, decoder active
  // S_BRANCH | one-cycle wait for LUT offset, decoder stalled
  // S_HALTED | program finished, waiting for Start
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BRANCH, S_HALTED} state_t;

  localparam int EXT_W = (ADDR_W > 11) ? ADDR_W : 11;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        lut_index_q, lut_index_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [EXT_W-1:0]  offset_ext;
  logic              busy;
`ifdef BRANCH_COUNT_EN
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
`endif

  // Offset is sign-extended first; the cast below then keeps only the low ADDR_W bits.
  assign offset_ext = EXT_W'(signed'(LutOut));
  assign busy       = (state_q == S_RUN) || (state_q == S_BRANCH);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    lut_index_d = lut_index_q;
    cycles_d    = cycles_q;
`ifdef BRANCH_COUNT_EN
    branch_cnt_d = branch_cnt_q;
`endif
    if (busy && (cycles_q != '1)) begin
      cycles_d = cycles_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          pc_d     = StartAddr;
          cycles_d = '0;
          state_d  = S_RUN;
`ifdef BRANCH_COUNT_EN
          branch_cnt_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (Halt) begin
          state_d = S_HALTED;
        end else if (BranchEn) begin
          lut_index_d = BranchSel;
          state_d     = S_BRANCH;
`ifdef BRANCH_COUNT_EN
          if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
`endif
        end else begin
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      S_BRANCH: begin
        pc_d    = pc_q + ADDR_W'(offset_ext);
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      lut_index_q <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      lut_index_q <= lut_index_d;
      cycles_q    <= cycles_d;
    end
  end

`ifdef BRANCH_COUNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) branch_cnt_q <= '0;
    else       branch_cnt_q <= branch_cnt_d;
  end
  assign BranchCount = branch_cnt_q;
`endif

  assign PC       = pc_q;
  assign LutIndex = lut_index_q;
  assign Stall    = (state_q == S_BRANCH);
  assign Busy     = busy;
  assign Done     = (state_q == S_HALTED);
  assign Cycles   = cycles_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic [ADDR_W-1:0] StartAddr = '0;
  logic              Halt = 1'b0;
  logic              BranchEn = 1'b0;
  logic [3:0]        BranchSel = '0;
  logic [10:0]       LutOut;
  logic [3:0]        LutIndex;
  logic [ADDR_W-1:0] PC;
  logic              Stall, Busy, Done;
  logic [CNT_W-1:0]  Cycles;
`ifdef BRANCH_COUNT_EN
  logic [CNT_W-1:0]  BranchCount;
`endif

  logic [10:0] lut [16];
  assign LutOut = lut[LutIndex];

  pc_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Halt(Halt),
    .BranchEn(BranchEn), .BranchSel(BranchSel), .LutOut(LutOut), .LutIndex(LutIndex),
    .PC(PC), .Stall(Stall), .Busy(Busy), .Done(Done), .Cycles(Cycles)
`ifdef BRANCH_COUNT_EN
    , .BranchCount(BranchCount)
`endif
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // reference model: program position, status flags and counters as plain integers
  int m_pc, m_cycles, m_bc, m_idx;
  bit m_busy, m_done, m_pend;

  typedef struct {
    int st; int ad; int h; int b; int s;
    int pc; int busy; int done; int stall; int idx; int cyc; int bc;
  } vec_t;
  vec_t vecs[22];

  function automatic vec_t mk(int st, int ad, int h, int b, int s, int pc, int busy,
                              int done, int stall, int idx, int cyc, int bc);
    vec_t v;
    v.st = st; v.ad = ad; v.h = h; v.b = b; v.s = s;
    v.pc = pc; v.busy = busy; v.done = done; v.stall = stall; v.idx = idx;
    v.cyc = cyc; v.bc = bc;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_bc(input string name, input int exp);
`ifdef BRANCH_COUNT_EN
    check(name, int'(BranchCount), exp);
`else
    if (exp < 0) $display("note: unexpected negative count %0d", exp);
`endif
  endtask

  task automatic model_reset();
    m_pc = 0; m_cycles = 0; m_bc = 0; m_idx = 0;
    m_busy = 0; m_done = 0; m_pend = 0;
  endtask

  task automatic model_edge(input int st, input int ad, input int h, input int b, input int s);
    int off;
    if (m_busy) begin
      m_cycles = (m_cycles < CMAX) ? m_cycles + 1 : CMAX;
      if (m_pend) begin
        off = int'(lut[m_idx]);
        if (off >= 1024) off -= 2048;
        m_pc = (((m_pc + off) % DEPTH) + DEPTH) % DEPTH;
        m_pend = 0;
      end else if (h != 0) begin
        m_busy = 0;
        m_done = 1;
      end else if (b != 0) begin
        m_idx = s;
        m_pend = 1;
        m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
    end else if (st != 0) begin
      m_pc = ad; m_cycles = 0; m_bc = 0;
      m_busy = 1; m_done = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_pc"},    int'(PC),       m_pc);
    check({tag, "_busy"},  int'(Busy),     int'(m_busy));
    check({tag, "_done"},  int'(Done),     int'(m_done));
    check({tag, "_stall"}, int'(Stall),    int'(m_pend));
    check({tag, "_idx"},   int'(LutIndex), m_idx);
    check({tag, "_cyc"},   int'(Cycles),   m_cycles);
    check_bc({tag, "_bc"}, m_bc);
  endtask

  task automatic drive(input int st, input int ad, input int h, input int b, input int s);
    Start     = (st != 0);
    StartAddr = ADDR_W'(ad);
    Halt      = (h != 0);
    BranchEn  = (b != 0);
    BranchSel = 4'(s);
  endtask

  task automatic cycle(input int st, input int ad, input int h, input int b, input int s,
                       input string tag);
    drive(st, ad, h, b, s);
    @(posedge Clk);
    model_edge(st, ad, h, b, s);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut[i] = 11'd0;
    lut[0] = 11'd1678;   // -370
    lut[1] = 11'd1601;   // -447
    lut[2] = 11'd3;

    // reset state while Reset is still held
    #2;
    check("rst_pc", int'(PC), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_stall", int'(Stall), 0);
    check("rst_idx", int'(LutIndex), 0);
    check("rst_cyc", int'(Cycles), 0);
    check_bc("rst_bc", 0);
    @(negedge Clk);
    Reset = 1'b0;

    //            st  ad  h b s    pc  bsy dn st idx cyc bc
    vecs[0]  = mk(1,   5, 0,0,0,    5, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0,   0, 0,0,0,    6, 1, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0,   0, 0,0,0,    7, 1, 0, 0, 0, 2, 0);
    vecs[3]  = mk(0,   0, 0,0,0,    8, 1, 0, 0, 0, 3, 0);
    vecs[4]  = mk(0,   0, 0,0,0,    9, 1, 0, 0, 0, 4, 0);
    vecs[5]  = mk(1, 100, 0,0,0,   10, 1, 0, 0, 0, 5, 0);
    vecs[6]  = mk(0,   0, 0,1,2,   10, 1, 0, 1, 2, 6, 1);
    vecs[7]  = mk(1, 200, 1,1,7,   13, 1, 0, 0, 2, 7, 1);
    vecs[8]  = mk(0,   0, 0,0,0,   14, 1, 0, 0, 2, 8, 1);
    vecs[9]  = mk(0,   0, 1,1,5,   14, 0, 1, 0, 2, 9, 1);
    vecs[10] = mk(0,   0, 0,1,3,   14, 0, 1, 0, 2, 9, 1);
    vecs[11] = mk(1, 400, 0,0,0,  400, 1, 0, 0, 2, 0, 0);
    vecs[12] = mk(0,   0, 0,1,0,  400, 1, 0, 1, 0, 1, 1);
    vecs[13] = mk(0,   0, 0,0,0,   30, 1, 0, 0, 0, 2, 1);
    vecs[14] = mk(1,  77, 1,0,0,   30, 0, 1, 0, 0, 3, 1);
    vecs[15] = mk(1,  10, 0,0,0,   10, 1, 0, 0, 0, 0, 0);
    vecs[16] = mk(0,   0, 0,1,1,   10, 1, 0, 1, 1, 1, 1);
    vecs[17] = mk(0,   0, 0,0,0,  587, 1, 0, 0, 1, 2, 1);
    vecs[18] = mk(0,   0, 1,0,0,  587, 0, 1, 0, 1, 3, 1);
    vecs[19] = mk(1,1023, 0,0,0, 1023, 1, 0, 0, 1, 0, 0);
    vecs[20] = mk(0,   0, 0,0,0,    0, 1, 0, 0, 1, 1, 0);
    vecs[21] = mk(0,   0, 1,0,0,    0, 0, 1, 0, 1, 2, 0);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].st, vecs[i].ad, vecs[i].h, vecs[i].b, vecs[i].s);
      @(posedge Clk);
      #1;
      check($sformatf("v%0d_pc", i),    int'(PC),       vecs[i].pc);
      check($sformatf("v%0d_busy", i),  int'(Busy),     vecs[i].busy);
      check($sformatf("v%0d_done", i),  int'(Done),     vecs[i].done);
      check($sformatf("v%0d_stall", i), int'(Stall),    vecs[i].stall);
      check($sformatf("v%0d_idx", i),   int'(LutIndex), vecs[i].idx);
      check($sformatf("v%0d_cyc", i),   int'(Cycles),   vecs[i].cyc);
      check_bc($sformatf("v%0d_bc", i), vecs[i].bc);
    end

    // asynchronous reset in the middle of a program at PC=37
    do_reset();
    cycle(1, 30, 0, 0, 0, "mr_start");
    cycle(0, 0, 0, 1, 2, "mr_br");
    cycle(0, 0, 0, 0, 0, "mr_tgt");
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, "mr_step");
    check("mr_pc37", int'(PC), 37);
    check("mr_busy_before", int'(Busy), 1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("ar_pc", int'(PC), 0);
    check("ar_busy", int'(Busy), 0);
    check("ar_done", int'(Done), 0);
    check("ar_stall", int'(Stall), 0);
    check("ar_idx", int'(LutIndex), 0);
    check("ar_cyc", int'(Cycles), 0);
    check_bc("ar_bc", 0);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0, "ar_idle");

    // cycle counter saturation across a PC wrap-free long run
    cycle(1, 0, 0, 0, 0, "sat_start");
    for (int i = 0; i < 300; i++) cycle(0, 0, 0, 0, 0, "sat_run");
    check("sat_cyc_max", int'(Cycles), CMAX);
    check("sat_pc", int'(PC), 300);

    // branch counter saturation
    cycle(0, 0, 1, 0, 0, "bsat_halt");
    cycle(1, 500, 0, 0, 0, "bsat_start");
    for (int i = 0; i < 300; i++) begin
      cycle(0, 0, 0, 1, i % 16, "bsat_br");
      cycle(0, 0, 0, 0, 0, "bsat_apply");
    end
    check_bc("bsat_bc_max", CMAX);

    // randomized traffic against the model
    for (int i = 0; i < 16; i++) lut[i] = 11'($urandom_range(0, 2047));
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 11) == 0) ? 1 : 0, int'($urandom_range(0, DEPTH - 1)),
              ($urandom_range(0, 24) == 0) ? 1 : 0, ($urandom_range(0, 4) == 0) ? 1 : 0,
              int'($urandom_range(0, 15)), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
